// File: rtl/sha256_w_sched.sv
// sha256_w_sched
// SHA-256 message schedule generator. Accepts the sixteen 32-bit words of a
// message block over a valid/ready load port, then streams the schedule words
// W[0..ROUNDS-1] over a valid/ready output port. A 16-entry circular buffer
// holds the sliding window W[t-16..t-1]; each expanded word overwrites the
// oldest entry once the consumer accepts it.

module sha256_w_sched #(
    parameter int ROUNDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        abort,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    output logic        load_ready,
    output logic        w_valid,
    input  logic        w_ready,
    output logic [31:0] w_data,
    output logic [5:0]  w_index,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        GEN,
        DONE
    } state_t;

    localparam logic [5:0] T_LAST = 6'(ROUNDS - 1);

    state_t      state_q, state_d;
    logic [3:0]  ldcnt_q, ldcnt_d;
    logic [5:0]  t_q, t_d;
    logic        rdy_en_q, rdy_en_d;
    logic [31:0] wbuf_q [16];
    logic [31:0] wbuf_d [16];

    logic [3:0]  idx_t, idx_m2, idx_m7, idx_m15;
    logic [31:0] w_expand;
    logic [31:0] w_cur;
    logic        t_is_msg;
    logic        load_fire;
    logic        w_fire;

    // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Schedule datapath: circular-buffer taps use 4-bit wrap-around arithmetic
    always_comb begin
        idx_t    = t_q[3:0];
        idx_m2   = idx_t - 4'd2;
        idx_m7   = idx_t - 4'd7;
        idx_m15  = idx_t - 4'd15;
        t_is_msg = (t_q[5:4] == 2'b00);
        w_expand = sig1(wbuf_q[idx_m2]) + wbuf_q[idx_m7]
                 + sig0(wbuf_q[idx_m15]) + wbuf_q[idx_t];
        w_cur    = t_is_msg ? wbuf_q[idx_t] : w_expand;
    end

    // Output decode from the current state
    always_comb begin
        load_ready = ((state_q == IDLE) && rdy_en_q) || (state_q == LOAD);
        w_valid    = (state_q == GEN);
        w_data     = w_valid ? w_cur : '0;
        w_index    = w_valid ? t_q : '0;
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        load_fire  = load_valid && load_ready;
        w_fire     = w_valid && w_ready;
    end

    // Next-state, counter and buffer-write logic; abort overrides everything
    always_comb begin
        state_d  = state_q;
        ldcnt_d  = ldcnt_q;
        t_d      = t_q;
        rdy_en_d = 1'b1;
        wbuf_d   = wbuf_q;

        if (abort) begin
            state_d = IDLE;
            ldcnt_d = '0;
            t_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_fire) begin
                        wbuf_d[0] = load_data;
                        ldcnt_d   = 4'd1;
                        state_d   = LOAD;
                    end
                end
                LOAD: begin
                    if (load_fire) begin
                        wbuf_d[ldcnt_q] = load_data;
                        ldcnt_d         = ldcnt_q + 4'd1;
                        if (ldcnt_q == 4'd15) begin
                            state_d = GEN;
                            t_d     = '0;
                        end
                    end
                end
                GEN: begin
                    if (w_fire) begin
                        if (!t_is_msg) begin
                            wbuf_d[idx_t] = w_expand;
                        end
                        t_d = t_q + 6'd1;
                        if (t_q == T_LAST) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    t_d     = '0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Control state register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ldcnt_q  <= '0;
            t_q      <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ldcnt_q  <= ldcnt_d;
            t_q      <= t_d;
            rdy_en_q <= rdy_en_d;
        end
    end

    // Window buffer storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        wbuf_q <= wbuf_d;
    end

endmodule

// File: tb/tb_sha256_w_sched.sv
// tb_sha256_w_sched
// Self-checking bench: a flat SHA-256 schedule model (W[t] from W[t-2], W[t-7],
// W[t-15], W[t-16]) is compared with the streamed output of a 64-round and a
// 16-round instance under random data and random consumer back-pressure.

module tb_sha256_w_sched;

    typedef logic [31:0] blk_t [16];
    typedef logic [31:0] wv_t [64];

    logic        clk;
    logic        rst_n;
    logic        abort;
    logic        load_valid;
    logic [31:0] load_data;
    logic        w_ready;

    logic        load_ready, w_valid, busy, done;
    logic [31:0] w_data;
    logic [5:0]  w_index;

    logic        load_ready16, w_valid16, busy16, done16;
    logic [31:0] w_data16;
    logic [5:0]  w_index16;

    int n_cmp = 0;
    int n_bad = 0;

    sha256_w_sched #(.ROUNDS(64)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .abort      (abort),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_data     (w_data),
        .w_index    (w_index),
        .busy       (busy),
        .done       (done)
    );

    sha256_w_sched #(.ROUNDS(16)) u_dut16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .abort      (abort),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready16),
        .w_valid    (w_valid16),
        .w_ready    (w_ready),
        .w_data     (w_data16),
        .w_index    (w_index16),
        .busy       (busy16),
        .done       (done16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
    endfunction

    function automatic wv_t ref_sched(input blk_t m);
        wv_t w;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) w[t] = m[t];
            else        w[t] = ref_s1(w[t-2]) + w[t-7] + ref_s0(w[t-15]) + w[t-16];
        end
        return w;
    endfunction

    function automatic blk_t abc_blk();
        blk_t b;
        for (int i = 0; i < 16; i++) b[i] = 32'h0;
        b[0]  = 32'h61626380;
        b[15] = 32'h00000018;
        return b;
    endfunction

    function automatic blk_t rand_blk();
        blk_t b;
        for (int i = 0; i < 16; i++) b[i] = $urandom;
        return b;
    endfunction

    // ---------------- stimulus drivers ----------------
    task automatic load_block(input blk_t m, input bit gapped,
                              output int acc, output int rdy_err);
        int  i;
        bit  ph;
        i = 0; ph = 1'b0; rdy_err = 0;
        abort = 1'b0;
        for (int cyc = 0; cyc < 100 && i < 16; cyc++) begin
            @(negedge clk);
            if (load_ready !== 1'b1) rdy_err++;
            ph = !ph;
            if (gapped && !ph) begin
                load_valid = 1'b0;
                load_data  = $urandom;
            end else begin
                load_valid = 1'b1;
                load_data  = m[i];
                if (load_ready === 1'b1) i++;
            end
        end
        acc = i;
    endtask

    // mode 0: run to completion, 1: abort at index stop_at, 2: stall and return at stop_at
    task automatic run_gen(input int rounds, input bit rnd, input int mode, input int stop_at,
                           output wv_t got, output int n, output int idx_err,
                           output int stall_err, output int done_cnt, output int first_v);
        bit          held;
        logic [31:0] hd;
        logic [5:0]  hi;
        held = 1'b0; hd = '0; hi = '0;
        n = 0; idx_err = 0; stall_err = 0; done_cnt = 0; first_v = -1;
        for (int i = 0; i < 64; i++) got[i] = '0;
        for (int cyc = 0; cyc < 1000 && n < rounds; cyc++) begin
            @(negedge clk);
            load_valid = 1'b0;
            if (done === 1'b1) done_cnt++;
            if (w_valid === 1'b1) begin
                if (first_v < 0) first_v = cyc;
                if (held && (w_data !== hd || w_index !== hi)) stall_err++;
                if (w_index !== 6'(n)) idx_err++;
            end
            if (mode != 0 && w_valid === 1'b1 && n == stop_at) begin
                if (mode == 1) begin
                    abort   = 1'b1;
                    w_ready = 1'b1;
                end else begin
                    w_ready = 1'b0;
                end
                break;
            end
            w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (w_valid === 1'b1 && w_ready) begin
                got[n] = w_data;
                n++;
                held = 1'b0;
            end else begin
                held = (w_valid === 1'b1);
                hd   = w_data;
                hi   = w_index;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; abort = 1'b0; load_valid = 1'b0; load_data = '0; w_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({load_ready, w_valid, busy, done, w_index, w_data} !== 42'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got lr=%b wv=%b busy=%b done=%b idx=%0d data=%h, required all 0",
                     load_ready, w_valid, busy, done, w_index, w_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({load_ready, busy, done} !== 3'b100) begin
            n_bad++;
            $display("FAIL reset_release: got lr=%b busy=%b done=%b, required 1 0 0", load_ready, busy, done);
        end
    endtask

    task automatic test_abc();
        blk_t m; wv_t exp, got;
        int acc, rerr, n, ierr, serr, dcnt, fv, bad;
        m = abc_blk(); exp = ref_sched(m);
        load_block(m, 1'b0, acc, rerr);
        run_gen(64, 1'b0, 0, 0, got, n, ierr, serr, dcnt, fv);
        n_cmp++;
        if (got[16] !== 32'h61626380) begin n_bad++; $display("FAIL abc_w16: got %h, required 61626380", got[16]); end
        n_cmp++;
        if (got[17] !== 32'h000F0000) begin n_bad++; $display("FAIL abc_w17: got %h, required 000f0000", got[17]); end
        n_cmp++;
        if (got[63] !== 32'h12B1EDEB) begin n_bad++; $display("FAIL abc_w63: got %h, required 12b1edeb", got[63]); end
        bad = -1;
        for (int i = 0; i < 64; i++) if (got[i] !== exp[i] && bad < 0) bad = i;
        n_cmp++;
        if (bad >= 0) begin n_bad++; $display("FAIL abc_seq: W[%0d] got %h, required %h", bad, got[bad], exp[bad]); end
        n_cmp++;
        if ({acc, rerr, n, ierr, dcnt, fv} !== {32'd16, 32'd0, 32'd64, 32'd0, 32'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL abc_flow: got acc=%0d rdy_err=%0d words=%0d idx_err=%0d early_done=%0d first_v=%0d, required 16 0 64 0 0 0",
                     acc, rerr, n, ierr, dcnt, fv);
        end
        @(negedge clk);
        n_cmp++;
        if ({done, w_valid, busy, load_ready} !== 4'b1010) begin
            n_bad++;
            $display("FAIL abc_done: got done=%b wv=%b busy=%b lr=%b, required 1 0 1 0", done, w_valid, busy, load_ready);
        end
        @(negedge clk);
        n_cmp++;
        if ({done, busy, load_ready} !== 3'b001) begin
            n_bad++;
            $display("FAIL abc_idle: got done=%b busy=%b lr=%b, required 0 0 1", done, busy, load_ready);
        end
    endtask

    task automatic test_stall();
        blk_t m; wv_t exp, got;
        int acc, rerr, n, ierr, serr, dcnt, fv, bad;
        for (int k = 0; k < 2; k++) begin
            m = (k == 0) ? abc_blk() : rand_blk();
            exp = ref_sched(m);
            load_block(m, 1'b0, acc, rerr);
            run_gen(64, 1'b1, 0, 0, got, n, ierr, serr, dcnt, fv);
            bad = -1;
            for (int i = 0; i < 64; i++) if (got[i] !== exp[i] && bad < 0) bad = i;
            n_cmp++;
            if (bad >= 0) begin n_bad++; $display("FAIL stall_seq%0d: W[%0d] got %h, required %h", k, bad, got[bad], exp[bad]); end
            n_cmp++;
            if ({n, ierr, serr} !== {32'd64, 32'd0, 32'd0}) begin
                n_bad++;
                $display("FAIL stall_hold%0d: got words=%0d idx_err=%0d stall_err=%0d, required 64 0 0", k, n, ierr, serr);
            end
            @(negedge clk);
            n_cmp++;
            if ({done, w_valid} !== 2'b10) begin n_bad++; $display("FAIL stall_done%0d: got done=%b wv=%b, required 1 0", k, done, w_valid); end
            @(negedge clk);
        end
    endtask

    task automatic test_gapped_load();
        blk_t m; wv_t exp, got;
        int acc, rerr, n, ierr, serr, dcnt, fv, bad;
        m = rand_blk(); exp = ref_sched(m);
        load_block(m, 1'b1, acc, rerr);
        run_gen(64, 1'b0, 0, 0, got, n, ierr, serr, dcnt, fv);
        n_cmp++;
        if ({acc, rerr, fv} !== {32'd16, 32'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL gap_load: got acc=%0d rdy_err=%0d first_v=%0d, required 16 0 0", acc, rerr, fv);
        end
        bad = -1;
        for (int i = 0; i < 64; i++) if (got[i] !== exp[i] && bad < 0) bad = i;
        n_cmp++;
        if (bad >= 0) begin n_bad++; $display("FAIL gap_seq: W[%0d] got %h, required %h", bad, got[bad], exp[bad]); end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_abort();
        blk_t m; wv_t exp, got;
        int acc, rerr, n, ierr, serr, dcnt, fv, bad;
        m = rand_blk();
        load_block(m, 1'b0, acc, rerr);
        run_gen(64, 1'b0, 1, 30, got, n, ierr, serr, dcnt, fv);
        @(negedge clk);
        abort = 1'b0;
        n_cmp++;
        if ({n, busy, w_valid, done} !== {32'd30, 3'b000}) begin
            n_bad++;
            $display("FAIL abort_idle: got words=%0d busy=%b wv=%b done=%b, required 30 0 0 0", n, busy, w_valid, done);
        end
        @(negedge clk);
        n_cmp++;
        if ({done, load_ready} !== 2'b01) begin n_bad++; $display("FAIL abort_nodone: got done=%b lr=%b, required 0 1", done, load_ready); end
        m = rand_blk(); exp = ref_sched(m);
        load_block(m, 1'b0, acc, rerr);
        run_gen(64, 1'b1, 0, 0, got, n, ierr, serr, dcnt, fv);
        bad = -1;
        for (int i = 0; i < 64; i++) if (got[i] !== exp[i] && bad < 0) bad = i;
        n_cmp++;
        if (bad >= 0 || ierr != 0) begin
            n_bad++;
            $display("FAIL abort_next_seq: first bad W[%0d] idx_err=%0d, required none", bad, ierr);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        blk_t m; wv_t exp, got;
        int acc, rerr, n, ierr, serr, dcnt, fv, bad;
        m = rand_blk();
        load_block(m, 1'b0, acc, rerr);
        run_gen(64, 1'b0, 2, 40, got, n, ierr, serr, dcnt, fv);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({w_valid, busy, w_index} !== 8'h00) begin
            n_bad++;
            $display("FAIL async_reset: got wv=%b busy=%b idx=%0d before clk edge, required 0 0 0", w_valid, busy, w_index);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        m = rand_blk(); exp = ref_sched(m);
        load_block(m, 1'b0, acc, rerr);
        run_gen(64, 1'b0, 0, 0, got, n, ierr, serr, dcnt, fv);
        bad = -1;
        for (int i = 0; i < 64; i++) if (got[i] !== exp[i] && bad < 0) bad = i;
        n_cmp++;
        if (bad >= 0 || n != 64 || rerr != 0) begin
            n_bad++;
            $display("FAIL async_next_seq: first bad W[%0d] words=%0d rdy_err=%0d, required none 64 0", bad, n, rerr);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        blk_t m; wv_t exp, got;
        int acc, rerr, n, ierr, serr, dcnt, fv, bad;
        for (int k = 0; k < 3; k++) begin
            m = rand_blk(); exp = ref_sched(m);
            load_block(m, k[0], acc, rerr);
            run_gen(64, 1'b1, 0, 0, got, n, ierr, serr, dcnt, fv);
            bad = -1;
            for (int i = 0; i < 64; i++) if (got[i] !== exp[i] && bad < 0) bad = i;
            n_cmp++;
            if (bad >= 0 || serr != 0 || ierr != 0) begin
                n_bad++;
                $display("FAIL b2b_seq%0d: first bad W[%0d] stall_err=%0d idx_err=%0d, required none 0 0", k, bad, serr, ierr);
            end
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_rounds16();
        blk_t m;
        int acc, rerr, dcnt;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        m = rand_blk();
        load_block(m, 1'b0, acc, rerr);
        dcnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            load_valid = 1'b0;
            w_ready    = 1'b1;
            if (done16 === 1'b1) dcnt++;
            n_cmp++;
            if ({w_valid16, w_index16, w_data16} !== {1'b1, 6'(i), m[i]}) begin
                n_bad++;
                $display("FAIL r16_word%0d: got wv=%b idx=%0d data=%h, required 1 %0d %h",
                         i, w_valid16, w_index16, w_data16, i, m[i]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({done16, w_valid16, dcnt} !== {2'b10, 32'd0}) begin
            n_bad++;
            $display("FAIL r16_done: got done=%b wv=%b early_done=%0d, required 1 0 0", done16, w_valid16, dcnt);
        end
        @(negedge clk);
        n_cmp++;
        if ({done16, busy16, load_ready16} !== 3'b001) begin
            n_bad++;
            $display("FAIL r16_idle: got done=%b busy=%b lr=%b, required 0 0 1", done16, busy16, load_ready16);
        end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_stall();
        test_gapped_load();
        test_abort();
        test_async_reset();
        test_back_to_back();
        test_rounds16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sha256_w_sched.md
SHA256_W_SCHED -- requirements
Module: sha256_w_sched

Interface
REQ-001 The block SHALL have parameter ROUNDS, default 64, giving the number of schedule words W[0..ROUNDS-1] emitted per block; legal range 16..64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port abort, input, 1 bit: synchronous return to IDLE.
REQ-005 The block SHALL have port load_valid, input, 1 bit: load_data is valid.
REQ-006 The block SHALL have port load_data, input, 32 bits: message word, big-endian word order M[0] first.
REQ-007 The block SHALL have port load_ready, output, 1 bit: the block accepts a message word.
REQ-008 The block SHALL have port w_valid, output, 1 bit: w_data and w_index are valid.
REQ-009 The block SHALL have port w_ready, input, 1 bit: the consumer accepts w_data.
REQ-010 The block SHALL have port w_data, output, 32 bits: schedule word W[w_index].
REQ-011 The block SHALL have port w_index, output, 6 bits: round index t.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last word is accepted.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, GEN and DONE.
REQ-015 IDLE SHALL assert load_ready; a transfer (load_valid && load_ready) SHALL store M[0] into buf[0] and move the FSM to LOAD with ldcnt=1.
REQ-016 LOAD SHALL assert load_ready; each transfer SHALL write buf[ldcnt] and increment ldcnt; the transfer with ldcnt=15 SHALL move the FSM to GEN with t=0.
REQ-017 In LOAD, cycles with load_valid low SHALL change no state; load_ready SHALL be low in GEN and DONE.
REQ-018 GEN SHALL assert w_valid, with w_index=t.
REQ-019 In GEN, w_data SHALL be buf[t] for t<16.
REQ-020 In GEN, w_data SHALL be sigma1(buf[(t-2)%16]) + buf[(t-7)%16] + sigma0(buf[(t-15)%16]) + buf[t%16] mod 2^32 for t>=16.
REQ-021 sigma0(x) SHALL be ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
REQ-022 sigma1(x) SHALL be ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
REQ-023 ROTR SHALL be a 32-bit rotate right; SHR SHALL be a logical right shift with zero fill.
REQ-024 On a transfer (w_valid && w_ready) in GEN, buf[t%16] SHALL be written with w_data when t>=16, and t SHALL increment.
REQ-025 While w_valid is high and w_ready is low, w_data and w_index SHALL be held stable.
REQ-026 Throughput SHALL be one word per cycle while w_ready is high.
REQ-027 The first w_valid SHALL occur in the cycle after the 16th load transfer.
REQ-028 The transfer with t=ROUNDS-1 SHALL move the FSM to DONE.
REQ-029 DONE SHALL assert done for exactly one cycle, then move the FSM to IDLE; w_valid SHALL be low in DONE.
REQ-030 abort high SHALL move the FSM to IDLE at the next edge from any state and clear ldcnt and t; no done pulse SHALL be produced.
REQ-031 abort SHALL take priority over a simultaneous load or w transfer; the word presented in that cycle is discarded.
REQ-032 The index arithmetic t%16 SHALL use the low 4 bits of t; wrap of the circular buffer SHALL be seamless across every multiple of 16.
REQ-033 The sigma and sum datapath SHALL be combinational from buf; no carry or width above 32 bits SHALL be retained.

Reset
REQ-034 While rst_n is low, the FSM SHALL be IDLE and ldcnt=0, t=0.
REQ-035 During reset, w_valid, done and busy SHALL be 0, w_data and w_index SHALL be 0, and load_ready SHALL be 0.
REQ-036 After rst_n rises, load_ready SHALL be 1 from the first clk edge.
REQ-037 Assertion of rst_n low mid-LOAD or mid-GEN SHALL take effect immediately, without waiting for clk; buf contents need not be cleared.

Verification
REQ-038 Load "abc" padded block (M0=0x61626380, M1..M14=0, M15=0x00000018), w_ready tied 1 -> W16=0x61626380, W17=0x000F0000, W63=0x12B1EDEB, w_index 0..63 contiguous, done pulses once, busy low afterwards.
REQ-039 Same block with w_ready toggled pseudo-randomly -> identical W sequence; w_data/w_index stable during every stall.
REQ-040 load_valid gapped (every other cycle) -> 16 words accepted in order, first w_valid one cycle after the last load transfer.
REQ-041 abort asserted at t=30 with w_ready=1 -> IDLE next cycle, no done pulse, next block processes correctly from W0.
REQ-042 rst_n pulsed low asynchronously mid-GEN (t=40) -> w_valid and busy drop without a clk edge; a new block after reset produces the reference W sequence.
REQ-043 ROUNDS=16 -> 16 words emitted, W0..W15 equal M0..M15, done follows W15.
